// File: rtl/lim_cmd_initiator.sv
// -----------------------------------------------------------------------------
// lim_cmd_initiator
// Bus-master end of data port "b" of the logic-in-memory RAM. It accepts one
// LiM command at a time and runs it as a fixed sequence on the RAM port:
//   1. program the funct cell with {asize, opcode};
//   2. issue the single or range access;
//   3. wait for the variable-latency rvalid, bounded by TIMEOUT_CYCLES;
//   4. optionally clear the funct cell back to 0;
//   5. return a response.
// Commands that would touch the funct cell itself, or whose range runs past the
// end of the RAM, are rejected with an error and cause no bus traffic.
//
// Ports
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o           command handshake (ready only in IDLE)
//   cmd_we_i, cmd_opcode_i, cmd_asize_i command: store flag, LiM opcode, count
//   cmd_addr_i, cmd_be_i, cmd_wdata_i   start byte address, byte enables, data
//   rsp_valid_o / rsp_ready_i           response handshake, held until taken
//   rsp_rdata_o, rsp_err_o              result word, reject/timeout flag
//   en_b_o, gnt_b_o                     RAM port request (gnt mirrors en)
//   addr_b_o, wdata_b_o, we_b_o, be_b_o RAM port address, data, write, enables
//   rdata_b_i, rvalid_b_i               RAM port read data, completion
// -----------------------------------------------------------------------------
module lim_cmd_initiator #(
  parameter int ADDR_WIDTH     = 10,
  parameter int LIM_FUNCT_ADDR = (2**ADDR_WIDTH)/32-4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AUTO_CLEAR     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [2:0]            cmd_opcode_i,
  input  logic [28:0]           cmd_asize_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [3:0]            cmd_be_i,
  input  logic [31:0]           cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  en_b_o,
  output logic [ADDR_WIDTH-1:0] addr_b_o,
  output logic [31:0]           wdata_b_o,
  output logic                  we_b_o,
  output logic [3:0]            be_b_o,
  output logic                  gnt_b_o,
  input  logic [31:0]           rdata_b_i,
  input  logic                  rvalid_b_i
);

  localparam logic [ADDR_WIDTH-1:0] FUNCT_ADDR = ADDR_WIDTH'(LIM_FUNCT_ADDR);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Range end is computed wide enough that a huge asize can never wrap.
  localparam int SUM_W = ADDR_WIDTH + 31;

  typedef enum logic [2:0] {
    IDLE, PROG, ISSUE, WAIT, CLEAR, RESP
  } state_e;

  // Where the sequence goes once the data access has completed or timed out.
  localparam state_e AFTER_ACCESS = (AUTO_CLEAR != 0) ? CLEAR : RESP;

  state_e                  state_q, state_d;
  logic                    cmd_we_q, cmd_we_d;
  logic [2:0]              cmd_opcode_q, cmd_opcode_d;
  logic [28:0]             cmd_asize_q, cmd_asize_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
  logic [3:0]              cmd_be_q, cmd_be_d;
  logic [31:0]             cmd_wdata_q, cmd_wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [SUM_W-1:0]        range_end;
  logic                    is_range;
  logic                    reject;

  // Accept-time checks on the incoming command.
  always_comb begin
    word_addr = {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00};
    is_range  = (cmd_asize_i >= 29'd2);
    range_end = SUM_W'(word_addr) + (SUM_W'(cmd_asize_i) << 2);
    reject    = (cmd_addr_i[ADDR_WIDTH-1:2] == FUNCT_ADDR[ADDR_WIDTH-1:2]) ||
                (is_range && (range_end > (SUM_W'(1) << ADDR_WIDTH)));
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    cmd_we_d     = cmd_we_q;
    cmd_opcode_d = cmd_opcode_q;
    cmd_asize_d  = cmd_asize_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_be_d     = cmd_be_q;
    cmd_wdata_d  = cmd_wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    cmd_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_rdata_o  = '0;
    rsp_err_o    = 1'b0;
    en_b_o       = 1'b0;
    addr_b_o     = '0;
    wdata_b_o    = '0;
    we_b_o       = 1'b0;
    be_b_o       = '0;

    unique case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          cmd_we_d     = cmd_we_i;
          cmd_opcode_d = cmd_opcode_i;
          cmd_asize_d  = cmd_asize_i;
          cmd_addr_d   = word_addr;
          cmd_be_d     = cmd_be_i;
          cmd_wdata_d  = cmd_wdata_i;
          rdata_d      = '0;
          cnt_d        = '0;
          err_d        = reject;
          state_d      = reject ? RESP : PROG;
        end
      end
      PROG: begin
        en_b_o    = 1'b1;
        we_b_o    = 1'b1;
        addr_b_o  = FUNCT_ADDR;
        wdata_b_o = {cmd_asize_q, cmd_opcode_q};
        be_b_o    = 4'hF;
        // The funct write is expected to complete in the same cycle; a missing
        // ack is remembered but the command still runs to completion.
        if (!rvalid_b_i) err_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        en_b_o    = 1'b1;
        we_b_o    = cmd_we_q;
        addr_b_o  = cmd_addr_q;
        wdata_b_o = cmd_wdata_q;
        be_b_o    = (cmd_asize_q >= 29'd2) ? 4'hF : cmd_be_q;
        if (rvalid_b_i) begin
          rdata_d = rdata_b_i;
          state_d = AFTER_ACCESS;
        end else begin
          cnt_d   = CNT_W'(1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (rvalid_b_i) begin
          rdata_d = rdata_b_i;
          state_d = AFTER_ACCESS;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          err_d   = 1'b1;
          state_d = AFTER_ACCESS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CLEAR: begin
        en_b_o   = 1'b1;
        we_b_o   = 1'b1;
        addr_b_o = FUNCT_ADDR;
        be_b_o   = 4'hF;
        if (!rvalid_b_i) err_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    gnt_b_o = en_b_o;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values computed for this cycle, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cmd_we_q     <= 1'b0;
      cmd_opcode_q <= '0;
      cmd_asize_q  <= '0;
      cmd_addr_q   <= '0;
      cmd_be_q     <= '0;
      cmd_wdata_q  <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_we_q     <= cmd_we_d;
      cmd_opcode_q <= cmd_opcode_d;
      cmd_asize_q  <= cmd_asize_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_be_q     <= cmd_be_d;
      cmd_wdata_q  <= cmd_wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lim_cmd_initiator.sv
// -----------------------------------------------------------------------------
// tb_lim_cmd_initiator
// Directed bench for lim_cmd_initiator with a 16-cycle timeout. A small RAM
// stand-in acks funct-cell writes in the same cycle and acks the data access
// either immediately, late (driven by the sequence) or never. Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_lim_cmd_initiator;

  localparam int AW = 10;
  localparam logic [AW-1:0] FUNCT = 10'h01C;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i = 1'b0;
  logic [2:0]    cmd_opcode_i = '0;
  logic [28:0]   cmd_asize_i = '0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [3:0]    cmd_be_i = '0;
  logic [31:0]   cmd_wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          en_b_o;
  logic [AW-1:0] addr_b_o;
  logic [31:0]   wdata_b_o;
  logic          we_b_o;
  logic [3:0]    be_b_o;
  logic          gnt_b_o;
  logic [31:0]   rdata_b_i;
  logic          rvalid_b_i;

  logic          funct_ack = 1'b1;
  logic          issue_ack = 1'b0;
  logic          late_rvalid = 1'b0;
  logic [31:0]   rdata_drv = '0;

  int checks = 0;
  int failures = 0;
  int en_count = 0;
  int e0;
  int wait_cycles;

  assign rdata_b_i  = rdata_drv;
  assign rvalid_b_i = (en_b_o && ((addr_b_o == FUNCT) ? funct_ack : issue_ack)) || late_rvalid;

  lim_cmd_initiator #(
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(16),
    .AUTO_CLEAR(1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_opcode_i(cmd_opcode_i), .cmd_asize_i(cmd_asize_i),
    .cmd_addr_i(cmd_addr_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .en_b_o(en_b_o), .addr_b_o(addr_b_o), .wdata_b_o(wdata_b_o),
    .we_b_o(we_b_o), .be_b_o(be_b_o), .gnt_b_o(gnt_b_o),
    .rdata_b_i(rdata_b_i), .rvalid_b_i(rvalid_b_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (en_b_o) en_count <= en_count + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  // Presents a command at a falling edge in IDLE; returns one cycle later,
  // i.e. in PROG for an accepted command or in RESP for a rejected one.
  task automatic send(input logic we, input logic [2:0] op, input logic [28:0] asize,
                      input logic [AW-1:0] addr, input logic [3:0] be, input logic [31:0] wd);
    cmd_we_i = we; cmd_opcode_i = op; cmd_asize_i = asize;
    cmd_addr_i = addr; cmd_be_i = be; cmd_wdata_i = wd;
    cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_ready", cmd_ready_o, 1);
    check("rst_en", en_b_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    step();
    rst_ni = 1'b1;
    step();

    // 1: single load, zero-latency RAM
    issue_ack = 1'b1; rdata_drv = 32'hDEADBEEF; e0 = en_count;
    send(1'b0, 3'd0, 29'd0, 10'h040, 4'h3, 32'h0);
    check("t1_prog_en", en_b_o, 1);
    check("t1_prog_gnt", gnt_b_o, 1);
    check("t1_prog_we", we_b_o, 1);
    check("t1_prog_addr", addr_b_o, FUNCT);
    check("t1_prog_wdata", wdata_b_o, 32'h0);
    check("t1_prog_be", be_b_o, 4'hF);
    check("t1_prog_ready", cmd_ready_o, 0);
    step();
    check("t1_issue_en", en_b_o, 1);
    check("t1_issue_we", we_b_o, 0);
    check("t1_issue_addr", addr_b_o, 10'h040);
    check("t1_issue_be", be_b_o, 4'h3);
    step();
    check("t1_clear_en", en_b_o, 1);
    check("t1_clear_addr", addr_b_o, FUNCT);
    check("t1_clear_wdata", wdata_b_o, 32'h0);
    check("t1_clear_rsp_valid", rsp_valid_o, 0);
    step();
    check("t1_rsp_valid", rsp_valid_o, 1);
    check("t1_rsp_rdata", rsp_rdata_o, 32'hDEADBEEF);
    check("t1_rsp_err", rsp_err_o, 0);
    check("t1_rsp_en", en_b_o, 0);
    take_rsp();
    check("t1_idle_ready", cmd_ready_o, 1);
    check("t1_idle_rsp_valid", rsp_valid_o, 0);
    check("t1_en_pulses", en_count - e0, 3);

    // 2: range store, rvalid after 8 cycles
    issue_ack = 1'b0; rdata_drv = 32'h12345678; e0 = en_count;
    send(1'b1, 3'd3, 29'd8, 10'h100, 4'h1, 32'hFFFF0000);
    check("t2_prog_wdata", wdata_b_o, 32'h43);
    step();
    check("t2_issue_be", be_b_o, 4'hF);
    check("t2_issue_we", we_b_o, 1);
    check("t2_issue_wdata", wdata_b_o, 32'hFFFF0000);
    check("t2_issue_addr", addr_b_o, 10'h100);
    step();
    for (int i = 0; i < 7; i++) begin
      check("t2_wait_en", en_b_o, 0);
      check("t2_wait_rsp", rsp_valid_o, 0);
      step();
    end
    late_rvalid = 1'b1;
    step();
    late_rvalid = 1'b0;
    check("t2_clear_en", en_b_o, 1);
    check("t2_clear_wdata", wdata_b_o, 32'h0);
    step();
    check("t2_rsp_valid", rsp_valid_o, 1);
    check("t2_rsp_rdata", rsp_rdata_o, 32'h12345678);
    check("t2_rsp_err", rsp_err_o, 0);
    check("t2_en_pulses", en_count - e0, 3);
    take_rsp();

    // 3: no rvalid -> timeout after 16 WAIT cycles
    issue_ack = 1'b0;
    send(1'b0, 3'd0, 29'd0, 10'h080, 4'hF, 32'h0);
    step();
    step();
    wait_cycles = 0;
    while (!en_b_o && !rsp_valid_o && wait_cycles < 40) begin
      wait_cycles++;
      step();
    end
    check("t3_wait_cycles", wait_cycles, 16);
    check("t3_clear_en", en_b_o, 1);
    check("t3_clear_addr", addr_b_o, FUNCT);
    step();
    check("t3_rsp_valid", rsp_valid_o, 1);
    check("t3_rsp_err", rsp_err_o, 1);
    take_rsp();

    // 4: rejected commands, plus a range ending exactly at the top
    e0 = en_count;
    send(1'b1, 3'd1, 29'd0, 10'h01D, 4'hF, 32'h1);
    check("t4a_rsp_valid", rsp_valid_o, 1);
    check("t4a_rsp_err", rsp_err_o, 1);
    take_rsp();
    send(1'b1, 3'd1, 29'd8, 10'h3F0, 4'hF, 32'h1);
    check("t4b_rsp_valid", rsp_valid_o, 1);
    check("t4b_rsp_err", rsp_err_o, 1);
    take_rsp();
    check("t4_no_bus", en_count - e0, 0);
    issue_ack = 1'b1;
    send(1'b0, 3'd2, 29'd8, 10'h3E0, 4'hF, 32'h0);
    check("t4c_prog_en", en_b_o, 1);
    step();
    step();
    step();
    check("t4c_rsp_err", rsp_err_o, 0);
    take_rsp();

    // 5: response backpressure, next command waiting
    issue_ack = 1'b1; rdata_drv = 32'hA5A50001;
    send(1'b0, 3'd0, 29'd0, 10'h200, 4'hF, 32'h0);
    step();
    step();
    step();
    cmd_we_i = 1'b0; cmd_opcode_i = 3'd0; cmd_asize_i = 29'd0;
    cmd_addr_i = 10'h204; cmd_be_i = 4'hF; cmd_valid_i = 1'b1;
    rdata_drv = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", rsp_valid_o, 1);
      check("t5_hold_rdata", rsp_rdata_o, 32'hA5A50001);
      check("t5_hold_ready", cmd_ready_o, 0);
      step();
    end
    take_rsp();
    check("t5_next_ready", cmd_ready_o, 1);
    step();
    cmd_valid_i = 1'b0;
    check("t5_next_prog_addr", addr_b_o, FUNCT);
    step();
    check("t5_next_issue_addr", addr_b_o, 10'h204);
    step();
    step();
    check("t5_next_rdata", rsp_rdata_o, 32'h0BADF00D);
    take_rsp();

    // 6: reset during WAIT, late rvalid afterwards
    issue_ack = 1'b0;
    send(1'b0, 3'd0, 29'd0, 10'h300, 4'hF, 32'h0);
    step();
    step();
    step();
    #1 rst_ni = 1'b0;
    #1;
    check("t6_rst_ready", cmd_ready_o, 1);
    check("t6_rst_en", en_b_o, 0);
    check("t6_rst_gnt", gnt_b_o, 0);
    check("t6_rst_addr", addr_b_o, 0);
    check("t6_rst_rsp_valid", rsp_valid_o, 0);
    step();
    rst_ni = 1'b1;
    late_rvalid = 1'b1;
    step();
    late_rvalid = 1'b0;
    check("t6_after_ready", cmd_ready_o, 1);
    check("t6_after_rsp_valid", rsp_valid_o, 0);
    step();
    check("t6_after_en", en_b_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
